buffer_slot_store: RTL and testbench
====================================

// Module: buffer_slot_store
// PURPOSE
//  Slot-addressed storage buffer that fills bs entries and publishes the occupancy bitmap as candidate_list.
//  Consumes the slot index chosen by the mapping-table selector and returns that entry, freeing the slot.
//  Sits on the write side of the random-selection path: writer -> buffer_slot_store -> mapping table -> pop.
// PARAMETERS
//  bs  16  number of buffer slots; power of two, >=2
//  DW  8   data width of one entry
// PORTS
//  clk            in   1              single clock, rising edge
//  rst            in   1              synchronous, active-high reset
//  flush          in   1              synchronous clear of all slots
//  in_valid       in   1              write request
//  in_data        in   DW             write data
//  in_ready       out  1              slot free; write accepted when in_valid && in_ready
//  candidate_list out  [0:bs-1]       registered occupancy bitmap; bit i = slot i holds data
//  pop_req        in   1              read/free request
//  sel_valid      in   1              selector has a valid index (valid_count)
//  sel_index      in   $clog2(bs)     slot to read (next_buffer_index)
//  out_valid      out  1              one-cycle pulse: out_data/out_index valid
//  out_data       out  DW             data of popped slot
//  out_index      out  $clog2(bs)     slot that was popped
//  pop_err        out  1              one-cycle pulse: pop rejected
//  occupancy      out  $clog2(bs)+1   number of occupied slots, 0..bs
//  full           out  1              occupancy == bs
//  empty          out  1              occupancy == 0
// BEHAVIOUR
//  Reset (rst=1 at posedge): candidate_list=0, occupancy=0, out_valid=0, out_data=0, out_index=0, pop_err=0.
//   in_ready=1, full=0, empty=1 after reset. Data array is not reset; contents of free slots are don't-care.
//  Write: accepted when in_valid && in_ready. in_ready = !full, from registered state only.
//   Data goes into the lowest-index free slot of the current (pre-edge) bitmap. That bit is set at the edge.
//  Pop: accepted when pop_req && sel_valid && candidate_list[sel_index].
//   On the next cycle: out_valid=1, out_data=mem[sel_index], out_index=sel_index.
//   The slot bit is cleared at the same edge. Read latency is 1 cycle.
//  Pop rejected when pop_req && (!sel_valid || !candidate_list[sel_index]).
//   pop_err pulses the next cycle, out_valid=0, and no state changes.
//  out_valid and pop_err last exactly one cycle. out_data/out_index hold their last value when out_valid=0.
//  Simultaneous write and pop in one cycle: both take effect.
//   The write never targets the slot being freed, because it uses the pre-edge bitmap.
//   Net occupancy change is 0.
//  Full: in_ready=0 even if a pop is accepted in the same cycle. The freed slot is writable from the next cycle.
//  Empty: every pop is rejected with pop_err.
//  flush: at the edge, clears candidate_list and occupancy, forces out_valid=0 and pop_err=0.
//   Same-cycle writes and pops are ignored. rst has priority over flush.
//  occupancy = popcount(candidate_list), maintained as a counter: +1 on write, -1 on pop.
//   Never wraps; it must match the bitmap every cycle.
//  Reset or flush asserted mid-stream discards all stored entries and any pending output pulse.
// TESTING
//  1 Reset then 3 writes (0xA1,0xA2,0xA3) -> candidate_list=1110_0000_0000_0000, occupancy=3, empty=0.
//  2 Fill 16 writes -> full=1, in_ready=0. A 17th in_valid is not stored; occupancy stays 16.
//  3 Slots 0..3 hold 0x10..0x13. Pop with sel_index=2 -> next cycle out_valid=1, out_data=0x12, out_index=2.
//    Afterwards bit 2 is clear and occupancy=3.
//  4 Pop with sel_index=5 on an unoccupied slot, or with sel_valid=0 -> pop_err pulse, state unchanged.
//    Pop while empty -> pop_err pulse.
//  5 Full buffer, pop index 7 plus in_valid in the same cycle -> write rejected, slot 7 freed.
//    Next cycle a write lands in slot 7 and full=1 again.
//  6 Occupancy 5, flush=1 with in_valid and pop_req also high -> next cycle occupancy=0, empty=1, no out_valid.
//    rst mid-stream gives the same result.

Source files
------------

// File: rtl/buffer_slot_store.sv
// ---------------------------------------------------------------------------
// buffer_slot_store
//   Slot-addressed storage buffer. Writes fill the lowest-index free slot and
//   the registered occupancy bitmap is published as candidate_list. An
//   external selector picks an occupied slot index. A pop returns that entry
//   one cycle later and frees the slot.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset (priority over flush)
//   flush          synchronous clear of all slots and pending output pulses
//   in_valid       write request
//   in_data        write data
//   in_ready       a slot is free (registered state only)
//   candidate_list occupancy bitmap, bit i = slot i holds data
//   pop_req        read/free request
//   sel_valid      selector has a valid index
//   sel_index      slot to read
//   out_valid      one-cycle pulse, out_data/out_index valid
//   out_data       data of popped slot (holds when out_valid=0)
//   out_index      slot that was popped (holds when out_valid=0)
//   pop_err        one-cycle pulse, pop rejected
//   occupancy      number of occupied slots, 0..bs
//   full / empty   occupancy == bs / occupancy == 0
// ---------------------------------------------------------------------------
module buffer_slot_store #(
  parameter int bs = 16,
  parameter int DW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  output logic [0:bs-1]          candidate_list,
  input  logic                   pop_req,
  input  logic                   sel_valid,
  input  logic [$clog2(bs)-1:0]  sel_index,
  output logic                   out_valid,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(bs)-1:0]  out_index,
  output logic                   pop_err,
  output logic [$clog2(bs):0]    occupancy,
  output logic                   full,
  output logic                   empty
);

  localparam int IW = $clog2(bs);
  localparam int CW = IW + 1;

  logic [0:bs-1]   r_bitmap;
  logic [CW-1:0]   r_count;
  logic [DW-1:0]   r_mem [bs];
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic [IW-1:0]   r_out_index;
  logic            r_pop_err;

  logic            w_full;
  logic            w_wr;
  logic            w_pop_hit;
  logic            w_pop_rej;
  logic [IW-1:0]   w_free_idx;
  logic [0:bs-1]   w_bitmap_nxt;

  // Status comes from registered state only, so an accepted pop in a full
  // cycle does not open in_ready until the next cycle.
  assign w_full    = (r_count == CW'(bs));
  assign w_wr      = in_valid && !w_full;
  assign w_pop_hit = pop_req && sel_valid && r_bitmap[sel_index];
  assign w_pop_rej = pop_req && !w_pop_hit;

  // Lowest-index free slot: scan downward so the last hit is the lowest.
  // NOTE: every always_comb output gets a default first; otherwise a path that
  // leaves it unassigned infers a latch.
  always_comb begin
    w_free_idx = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (!r_bitmap[i]) w_free_idx = IW'(i);
    end
  end

  // The write slot is chosen from the pre-edge bitmap, so it can never be the
  // slot being freed by a same-cycle pop.
  always_comb begin
    w_bitmap_nxt = r_bitmap;
    if (w_pop_hit) w_bitmap_nxt[sel_index]  = 1'b0;
    if (w_wr)      w_bitmap_nxt[w_free_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitmap    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_pop_err   <= 1'b0;
    end else if (flush) begin
      r_bitmap    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_pop_err   <= 1'b0;
    end else begin
      r_bitmap    <= w_bitmap_nxt;
      r_out_valid <= w_pop_hit;
      r_pop_err   <= w_pop_rej;
      if (w_pop_hit) begin
        r_out_data  <= r_mem[sel_index];
        r_out_index <= sel_index;
      end
      unique case ({w_wr, w_pop_hit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the data array carries no reset; a slot is only read while its
  // bitmap bit is set, which implies it was written first.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr) r_mem[w_free_idx] <= in_data;
  end

  assign candidate_list = r_bitmap;
  assign occupancy      = r_count;
  assign full           = w_full;
  assign empty          = (r_count == '0);
  assign in_ready       = !w_full;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_index      = r_out_index;
  assign pop_err        = r_pop_err;

endmodule

// File: tb/tb_buffer_slot_store.sv
// ---------------------------------------------------------------------------
// tb_buffer_slot_store
//   Directed scenarios followed by randomized traffic, compared every cycle
//   against a slot-array reference model of the buffer.
// ---------------------------------------------------------------------------
module tb_buffer_slot_store;

  localparam int BS = 16;
  localparam int DW = 8;
  localparam int IW = $clog2(BS);

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, pop_req, sel_valid;
  logic [DW-1:0] in_data;
  logic [IW-1:0] sel_index;
  logic          in_ready, out_valid, pop_err, full, empty;
  logic [0:BS-1] candidate_list;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic [IW:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_occ [BS];
  logic [DW-1:0] m_mem [BS];
  bit            e_out_valid, e_pop_err;
  logic [DW-1:0] e_out_data;
  logic [IW-1:0] e_out_index;

  always #5 clk = ~clk;

  buffer_slot_store #(.bs(BS), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .candidate_list(candidate_list),
    .pop_req(pop_req), .sel_valid(sel_valid), .sel_index(sel_index),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .pop_err(pop_err), .occupancy(occupancy), .full(full), .empty(empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < BS; i++) c += m_occ[i];
    return c;
  endfunction

  function automatic logic [31:0] m_bitmap();
    logic [0:BS-1] b;
    for (int i = 0; i < BS; i++) b[i] = m_occ[i];
    return {16'b0, b};
  endfunction

  // Apply one clock edge of the buffer's rules to the model.
  task automatic model_step(input bit r, f, iv, input logic [DW-1:0] d,
                            input bit pr, sv, input int si);
    int  slot;
    bit  wr, hit;
    if (r) begin
      foreach (m_occ[i]) m_occ[i] = 0;
      e_out_valid = 0; e_pop_err = 0; e_out_data = '0; e_out_index = '0;
    end else if (f) begin
      foreach (m_occ[i]) m_occ[i] = 0;
      e_out_valid = 0; e_pop_err = 0;
    end else begin
      wr   = iv && (m_count() < BS);
      slot = -1;
      for (int i = 0; i < BS && slot < 0; i++) if (!m_occ[i]) slot = i;
      hit  = pr && sv && m_occ[si];
      e_out_valid = hit;
      e_pop_err   = pr && !hit;
      if (hit) begin
        e_out_data  = m_mem[si];
        e_out_index = IW'(si);
        m_occ[si]   = 0;
      end
      if (wr) begin
        m_occ[slot] = 1;
        m_mem[slot] = d;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int c = m_count();
    check({tag, ".bitmap"},    candidate_list, m_bitmap());
    check({tag, ".occupancy"}, occupancy, c);
    check({tag, ".full"},      full, (c == BS));
    check({tag, ".empty"},     empty, (c == 0));
    check({tag, ".in_ready"},  in_ready, (c != BS));
    check({tag, ".out_valid"}, out_valid, e_out_valid);
    check({tag, ".pop_err"},   pop_err, e_pop_err);
    check({tag, ".out_data"},  out_data, e_out_data);
    check({tag, ".out_index"}, out_index, e_out_index);
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare #1 after the edge.
  task automatic cyc(input string tag, input bit r, f, iv, input logic [DW-1:0] d,
                     input bit pr, sv, input int si);
    rst = r; flush = f; in_valid = iv; in_data = d;
    pop_req = pr; sel_valid = sv; sel_index = IW'(si);
    model_step(r, f, iv, d, pr, sv, si);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    cyc("reset", 1, 0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic wr(input string tag, input logic [DW-1:0] d);
    cyc(tag, 0, 0, 1, d, 0, 0, 0);
  endtask

  task automatic pop(input string tag, input bit sv, input int si);
    cyc(tag, 0, 0, 0, 8'h00, 1, sv, si);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_data = '0;
    pop_req = 0; sel_valid = 0; sel_index = '0;

    // 1: reset then three writes
    do_reset();
    check("t1.reset_empty", empty, 1);
    check("t1.reset_ready", in_ready, 1);
    wr("t1.w", 8'hA1); wr("t1.w", 8'hA2); wr("t1.w", 8'hA3);
    check("t1.bitmap", candidate_list, 16'hE000);
    check("t1.occ", occupancy, 3);

    // 2: fill, then an extra write is dropped
    do_reset();
    for (int i = 0; i < BS; i++) wr("t2.fill", 8'h40 + i[7:0]);
    check("t2.full", full, 1);
    check("t2.in_ready", in_ready, 0);
    wr("t2.extra", 8'hEE);
    check("t2.occ", occupancy, 16);

    // 3: pop slot 2 of four
    do_reset();
    for (int i = 0; i < 4; i++) wr("t3.w", 8'h10 + i[7:0]);
    pop("t3.pop", 1, 2);
    check("t3.out_valid", out_valid, 1);
    check("t3.out_data", out_data, 8'h12);
    check("t3.out_index", out_index, 2);
    check("t3.bitmap", candidate_list, 16'hD000);
    check("t3.occ", occupancy, 3);
    idle("t3.pulse_end");
    check("t3.out_valid_drop", out_valid, 0);
    check("t3.out_data_hold", out_data, 8'h12);

    // 4: rejected pops
    pop("t4.unocc", 1, 5);
    check("t4.unocc_err", pop_err, 1);
    pop("t4.noselv", 0, 0);
    check("t4.noselv_err", pop_err, 1);
    check("t4.noselv_occ", occupancy, 3);
    do_reset();
    pop("t4.empty", 1, 0);
    check("t4.empty_err", pop_err, 1);
    check("t4.empty_nov", out_valid, 0);

    // 5: full, pop 7 with simultaneous write; write rejected then refills 7
    for (int i = 0; i < BS; i++) wr("t5.fill", 8'h80 + i[7:0]);
    cyc("t5.popwr", 0, 0, 1, 8'h5A, 1, 1, 7);
    check("t5.occ", occupancy, 15);
    check("t5.out_data", out_data, 8'h87);
    check("t5.bit7", candidate_list[7], 0);
    wr("t5.refill", 8'h77);
    check("t5.full", full, 1);
    pop("t5.readback", 1, 7);
    check("t5.readback_data", out_data, 8'h77);

    // 6: flush and reset with concurrent traffic
    do_reset();
    for (int i = 0; i < 5; i++) wr("t6.w", 8'h60 + i[7:0]);
    cyc("t6.flush", 0, 1, 1, 8'h99, 1, 1, 0);
    check("t6.flush_occ", occupancy, 0);
    check("t6.flush_empty", empty, 1);
    check("t6.flush_nov", out_valid, 0);
    for (int i = 0; i < 5; i++) wr("t6.w2", 8'h70 + i[7:0]);
    pop("t6.pop", 1, 1);
    cyc("t6.rst", 1, 1, 1, 8'h99, 1, 1, 0);
    check("t6.rst_occ", occupancy, 0);
    check("t6.rst_nov", out_valid, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit r  = ($urandom_range(0, 299) == 0);
      bit f  = ($urandom_range(0, 79) == 0);
      bit iv = ($urandom_range(0, 99) < 55);
      bit pr = ($urandom_range(0, 99) < 45);
      bit sv = ($urandom_range(0, 9) < 8);
      cyc("rand", r, f, iv, 8'($urandom), pr, sv, $urandom_range(0, BS - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
